// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Two-master arbiter and sequencer for the shared 16-bit ALU. Each master
// hands over an operation (ctrl code plus two operands) on a valid/ready
// handshake. Grants alternate round-robin when both masters ask at once. The
// granted operation is latched into operand registers that drive the
// combinational ALU. One cycle later the ALU result and flags are captured
// into response registers. They are returned to the owning master on a
// second valid/ready handshake.
//
// Ports
//   clk, rst_n                  clock (rising edge) / async active-low reset
//   req{0,1}_valid/_ready       request handshake per master
//   req{0,1}_op/_a/_b           ALU ctrl code and operands per master
//   resp{0,1}_valid/_ready      response handshake per master
//   resp_data/_carry/_zero      shared result bus, qualified by respN_valid
//   resp_illegal                latched op was not a supported ctrl code
//   alu_a, alu_b, alu_ctrl      to the ALU, driven from operand registers
//   alu_out/_carry/_zero        from the ALU
//   busy                        high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int DW = 16,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  // master 0 request
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [CW-1:0] req0_op,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  // master 1 request
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [CW-1:0] req1_op,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  // responses
  output logic          resp0_valid,
  input  logic          resp0_ready,
  output logic          resp1_valid,
  input  logic          resp1_ready,
  output logic [DW-1:0] resp_data,
  output logic          resp_carry,
  output logic          resp_zero,
  output logic          resp_illegal,
  // ALU side
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [CW-1:0] alu_ctrl,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_carry,
  input  logic          alu_zero,
  // status
  output logic          busy
);

  localparam logic [CW-1:0] OP_AND = CW'(6'b000000);
  localparam logic [CW-1:0] OP_OR  = CW'(6'b000001);
  localparam logic [CW-1:0] OP_ADD = CW'(6'b000010);
  localparam logic [CW-1:0] OP_SUB = CW'(6'b000110);
  localparam logic [CW-1:0] OP_MUL = CW'(6'b001111);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t        state;
  logic          rr_ptr;
  logic          owner;
  logic [CW-1:0] op_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic          grant0;
  logic          grant1;
  logic          op_legal;
  logic          resp_done;

  // Grant decision. Only IDLE may grant. rr_ptr breaks a tie between two
  // simultaneous requesters. Gating with rst_n keeps both readys low while
  // reset is held, even if a master is already asserting valid.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~rr_ptr;
        grant1 = rr_ptr;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  // Only the five codes the ALU implements count as legal. Anything else
  // returns the ALU-default result and raises resp_illegal.
  always_comb begin
    op_legal = 1'b0;
    case (op_q)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL: op_legal = 1'b1;
      default:                               op_legal = 1'b0;
    endcase
  end

  // The response completes when the owner's valid meets its ready. The
  // non-owner's valid is low, so its ready is ignored here.
  assign resp_done = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_ctrl   = op_q;
  assign busy       = (state != IDLE);

  // Sequencer: IDLE latches the granted request, EXEC captures the ALU
  // result one cycle after the operands settle, and RESP holds the result
  // until the owner takes it. rr_ptr moves only on completion, and always
  // moves away from the master just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= 1'b0;
      owner        <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      resp0_valid  <= 1'b0;
      resp1_valid  <= 1'b0;
      resp_data    <= '0;
      resp_carry   <= 1'b0;
      resp_zero    <= 1'b0;
      resp_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            owner <= grant1;
            op_q  <= grant1 ? req1_op : req0_op;
            a_q   <= grant1 ? req1_a  : req0_a;
            b_q   <= grant1 ? req1_b  : req0_b;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (op_legal) begin
            resp_data    <= alu_out;
            resp_carry   <= alu_carry;
            resp_zero    <= alu_zero;
            resp_illegal <= 1'b0;
          end else begin
            resp_data    <= '0;
            resp_carry   <= 1'b0;
            resp_zero    <= 1'b1;
            resp_illegal <= 1'b1;
          end
          resp0_valid <= ~owner;
          resp1_valid <= owner;
          state       <= RESP;
        end
        RESP: begin
          if (resp_done) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            rr_ptr      <= ~owner;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Bench for alu_arbiter. It models the external ALU and keeps a
// transaction-level reference of the arbiter: pending requests per master,
// the preferred master, and the phase of the current transaction. Every
// cycle, DUT handshakes and response values are compared against that
// reference. The directed steps follow the intended use cases, and a
// randomized stretch follows them.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int DW = 16;
  localparam int CW = 6;

  localparam logic [5:0] OP_AND = 6'b000000;
  localparam logic [5:0] OP_OR  = 6'b000001;
  localparam logic [5:0] OP_ADD = 6'b000010;
  localparam logic [5:0] OP_SUB = 6'b000110;
  localparam logic [5:0] OP_MUL = 6'b001111;

  typedef struct {
    logic [15:0] data;
    logic        carry;
    logic        zero;
    logic        illegal;
  } resp_t;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [CW-1:0] req0_op, req1_op;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          resp0_valid, resp1_valid;
  logic          resp0_ready, resp1_ready;
  logic [DW-1:0] resp_data;
  logic          resp_carry, resp_zero, resp_illegal;
  logic [DW-1:0] alu_a, alu_b;
  logic [CW-1:0] alu_ctrl;
  logic [DW-1:0] alu_out;
  logic          alu_carry, alu_zero;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_phase;   // 0 idle, 1 executing, 2 responding
  int          m_owner;
  int          m_pref;
  logic [5:0]  m_op;
  logic [15:0] m_a, m_b;
  resp_t       m_exp;
  logic        p_valid[2];
  logic [5:0]  p_op[2];
  logic [15:0] p_a[2];
  logic [15:0] p_b[2];
  logic        r_rdy[2];
  int          grant_log[$];

  alu_arbiter #(.DW(DW), .CW(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_op      (req0_op),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_op      (req1_op),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .resp0_valid  (resp0_valid),
    .resp0_ready  (resp0_ready),
    .resp1_valid  (resp1_valid),
    .resp1_ready  (resp1_ready),
    .resp_data    (resp_data),
    .resp_carry   (resp_carry),
    .resp_zero    (resp_zero),
    .resp_illegal (resp_illegal),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ctrl     (alu_ctrl),
    .alu_out      (alu_out),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external combinational ALU
  always_comb begin
    logic [16:0] r;
    logic [31:0] prod;
    prod = 32'(alu_a) * 32'(alu_b);
    case (alu_ctrl)
      OP_AND:  r = {1'b0, alu_a & alu_b};
      OP_OR:   r = {1'b0, alu_a | alu_b};
      OP_ADD:  r = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB:  r = {1'b0, alu_a} - {1'b0, alu_b};
      OP_MUL:  r = prod[16:0];
      default: r = '0;
    endcase
    alu_out   = r[15:0];
    alu_carry = r[16];
    alu_zero  = (r[15:0] == 16'h0000);
  end

  // expected response computed directly from the operation's arithmetic
  function automatic resp_t ref_alu(input logic [5:0] op, input logic [15:0] a,
                                    input logic [15:0] b);
    resp_t r;
    int unsigned wide;
    r.illegal = 1'b0;
    case (op)
      OP_AND:  wide = int'(a & b);
      OP_OR:   wide = int'(a | b);
      OP_ADD:  wide = int'(a) + int'(b);
      OP_SUB:  wide = int'(a) - int'(b);
      OP_MUL:  wide = int'(a) * int'(b);
      default: begin wide = 0; r.illegal = 1'b1; end
    endcase
    r.data  = wide[15:0];
    r.carry = wide[16];
    r.zero  = (wide[15:0] == 16'h0000);
    return r;
  endfunction

  function automatic logic [5:0] rand_op();
    logic [5:0] ops[5];
    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL};
    if ($urandom_range(0, 5) == 0) return 6'($urandom);
    return ops[$urandom_range(0, 4)];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int m, input logic [5:0] op,
                               input logic [15:0] a, input logic [15:0] b);
    p_valid[m] = 1'b1;
    p_op[m]    = op;
    p_a[m]     = a;
    p_b[m]     = b;
  endtask

  task automatic reset_model();
    m_phase = 0;
    m_owner = 0;
    m_pref  = 0;
    m_op    = '0;
    m_a     = '0;
    m_b     = '0;
    for (int i = 0; i < 2; i++) p_valid[i] = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_req0_ready"},   req0_ready,   0);
    checkOutput({tag, "_req1_ready"},   req1_ready,   0);
    checkOutput({tag, "_resp0_valid"},  resp0_valid,  0);
    checkOutput({tag, "_resp1_valid"},  resp1_valid,  0);
    checkOutput({tag, "_resp_data"},    resp_data,    0);
    checkOutput({tag, "_resp_carry"},   resp_carry,   0);
    checkOutput({tag, "_resp_zero"},    resp_zero,    0);
    checkOutput({tag, "_resp_illegal"}, resp_illegal, 0);
    checkOutput({tag, "_alu_a"},        alu_a,        0);
    checkOutput({tag, "_alu_b"},        alu_b,        0);
    checkOutput({tag, "_alu_ctrl"},     alu_ctrl,     0);
    checkOutput({tag, "_busy"},         busy,         0);
  endtask

  // One clock cycle: compare registered outputs, drive inputs, compare the
  // combinational grant, advance the reference, then cross the edge.
  task automatic run_cycle();
    int g;
    int obs;
    checkOutput("busy",        busy,        32'(m_phase != 0));
    checkOutput("resp0_valid", resp0_valid, 32'(m_phase == 2 && m_owner == 0));
    checkOutput("resp1_valid", resp1_valid, 32'(m_phase == 2 && m_owner == 1));
    checkOutput("alu_a",    alu_a,    m_a);
    checkOutput("alu_b",    alu_b,    m_b);
    checkOutput("alu_ctrl", alu_ctrl, m_op);
    if (m_phase == 2) begin
      checkOutput("resp_data",    resp_data,    m_exp.data);
      checkOutput("resp_carry",   resp_carry,   m_exp.carry);
      checkOutput("resp_zero",    resp_zero,    m_exp.zero);
      checkOutput("resp_illegal", resp_illegal, m_exp.illegal);
    end
    req0_valid  = p_valid[0];
    req0_op     = p_op[0];
    req0_a      = p_a[0];
    req0_b      = p_b[0];
    req1_valid  = p_valid[1];
    req1_op     = p_op[1];
    req1_a      = p_a[1];
    req1_b      = p_b[1];
    resp0_ready = r_rdy[0];
    resp1_ready = r_rdy[1];
    #1;
    g = -1;
    if (m_phase == 0) begin
      if (p_valid[0] && p_valid[1]) g = m_pref;
      else if (p_valid[0])          g = 0;
      else if (p_valid[1])          g = 1;
    end
    checkOutput("req0_ready", req0_ready, 32'(g == 0));
    checkOutput("req1_ready", req1_ready, 32'(g == 1));
    obs = req0_ready ? 0 : (req1_ready ? 1 : -1);
    if (obs >= 0) grant_log.push_back(obs);
    case (m_phase)
      0: if (g >= 0) begin
           m_owner    = g;
           m_op       = p_op[g];
           m_a        = p_a[g];
           m_b        = p_b[g];
           m_exp      = ref_alu(p_op[g], p_a[g], p_b[g]);
           p_valid[g] = 1'b0;
           m_phase    = 1;
         end
      1: m_phase = 2;
      default: if (r_rdy[m_owner]) begin
                 m_pref  = 1 - m_owner;
                 m_phase = 0;
               end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_resp(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (m_phase == 2) break;
      run_cycle();
    end
    checkOutput({tag, "_reached_resp"}, 32'(m_phase == 2), 1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (m_phase == 0 && !p_valid[0] && !p_valid[1]) break;
      run_cycle();
    end
    checkOutput({tag, "_drained"}, 32'(m_phase == 0 && !p_valid[0] && !p_valid[1]), 1);
  endtask

  initial begin
    rst_n = 1'b1;
    req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0;
    resp0_ready = 0; resp1_ready = 0;
    r_rdy[0] = 1'b1;
    r_rdy[1] = 1'b1;
    reset_model();
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single ADD from master 0
    applyStimulus(0, OP_ADD, 16'h0003, 16'h0004);
    run_until_resp("add");
    checkOutput("add_valid", resp0_valid, 1);
    checkOutput("add_data",  resp_data,   16'h0007);
    checkOutput("add_carry", resp_carry,  0);
    checkOutput("add_zero",  resp_zero,   0);
    drain("add");

    // SUB equal operands and SUB with borrow from master 1
    applyStimulus(1, OP_SUB, 16'h0005, 16'h0005);
    run_until_resp("sub_eq");
    checkOutput("sub_eq_data", resp_data, 16'h0000);
    checkOutput("sub_eq_zero", resp_zero, 1);
    drain("sub_eq");
    applyStimulus(1, OP_SUB, 16'h0001, 16'h0002);
    run_until_resp("sub_borrow");
    checkOutput("sub_borrow_data",  resp_data,  16'hFFFF);
    checkOutput("sub_borrow_carry", resp_carry, 1);
    checkOutput("sub_borrow_zero",  resp_zero,  0);
    drain("sub_borrow");

    // contention: both masters always requesting, responses taken at once
    grant_log.delete();
    for (int c = 0; c < 18; c++) begin
      if (!p_valid[0]) applyStimulus(0, OP_ADD, 16'h0001, 16'h0001);
      if (!p_valid[1]) applyStimulus(1, OP_OR,  16'h00F0, 16'h000F);
      run_cycle();
    end
    checkOutput("contention_grants", grant_log.size(), 6);
    for (int i = 0; i < grant_log.size(); i++)
      checkOutput($sformatf("contention_grant%0d", i), grant_log[i], i % 2);
    drain("contention");

    // backpressure on master 0 while master 1 waits
    r_rdy[0] = 1'b0;
    applyStimulus(0, OP_MUL, 16'h0100, 16'h0100);
    applyStimulus(1, OP_ADD, 16'h0002, 16'h0003);
    run_until_resp("bp");
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_data",       resp_data,  16'h0000);
      checkOutput("bp_carry",      resp_carry, 1);
      checkOutput("bp_req1_ready", req1_ready, 0);
      run_cycle();
    end
    r_rdy[0] = 1'b1;
    drain("bp");

    // unsupported op code
    applyStimulus(0, 6'b000011, 16'h1234, 16'h0000);
    run_until_resp("illegal");
    checkOutput("illegal_flag", resp_illegal, 1);
    checkOutput("illegal_data", resp_data,    0);
    checkOutput("illegal_zero", resp_zero,    1);
    drain("illegal");

    // reset while master 1 is in EXEC, after master 0 moved rr_ptr to 1
    applyStimulus(0, OP_AND, 16'h00FF, 16'h0F0F);
    drain("pre_rst");
    applyStimulus(1, OP_OR, 16'h1111, 16'h2222);
    for (int i = 0; i < 5 && m_phase != 1; i++) run_cycle();
    checkOutput("rst_in_exec", 32'(m_phase == 1), 1);
    #3;
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check_reset_values("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    reset_model();
    grant_log.delete();
    applyStimulus(0, OP_ADD, 16'h0010, 16'h0020);
    applyStimulus(1, OP_ADD, 16'h0030, 16'h0040);
    run_until_resp("post_rst");
    checkOutput("post_rst_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    drain("post_rst");

    // randomized traffic with random response backpressure
    for (int c = 0; c < 600; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!p_valid[m] && $urandom_range(0, 2) == 0)
          applyStimulus(m, rand_op(), 16'($urandom), 16'($urandom));
        r_rdy[m] = ($urandom_range(0, 3) != 0);
      end
      run_cycle();
    end
    r_rdy[0] = 1'b1;
    r_rdy[1] = 1'b1;
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
